// File: rtl/au_sequencer.sv
// ---------------------------------------------------------------------------
// au_sequencer
//   Four-state controller (IDLE -> READ -> EXEC -> WB). It accepts one 16-bit
//   ALU instruction plus immediate through a valid/ready handshake. It reads
//   Rn/Rm from an internal 8x16 register file and presents them, with the
//   decoded opcode, mode and immediate, to an external combinational AU. It
//   captures the AU result and writes it back to Rd.
//
//   Instruction layout: [15:13] opcode, [12:11] mode, [10:8] Rd, [7:5] Rn,
//                       [4:2] Rm, [1:0] ignored.
//
//   Optional build macro: AU_SEQ_FLAGS_EN adds zero/negative result flags
//   (flag_z, flag_n). These flags update on every legal writeback.
// ---------------------------------------------------------------------------
module au_sequencer #(
  parameter int NREGS = 8,   // must be 8: register fields are 3 bits wide
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic [DW-1:0] imm,
  output logic [2:0]    au_opcode,
  output logic [1:0]    au_mode,
  output logic [DW:0]   au_imm,
  output logic [DW-1:0] au_rn_data,
  output logic [DW-1:0] au_rm_data,
  input  logic [DW-1:0] au_rd_data,
  output logic          done,
  output logic          err,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef AU_SEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e        state_q, state_d;

  // Latched instruction (bits [1:0] carry no information and are dropped).
  logic [15:2]   instr_q, instr_d;
  logic [DW-1:0] imm_q,   imm_d;

  // Registered AU drive. These hold their values while the sequencer idles.
  logic [2:0]    au_opcode_q, au_opcode_d;
  logic [1:0]    au_mode_q,   au_mode_d;
  logic [DW:0]   au_imm_q,    au_imm_d;
  logic [DW-1:0] au_rn_q,     au_rn_d;
  logic [DW-1:0] au_rm_q,     au_rm_d;

  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  // Decoded fields of the latched instruction.
  logic [2:0]    op_f;
  logic [1:0]    mode_f;
  logic [2:0]    rd_f, rn_f, rm_f;
  logic          op_legal;
  logic          accept;
  logic          wb_write;

  // The two low instruction bits are reserved and never decoded.
  logic          unused_instr_lsbs;
  assign unused_instr_lsbs = ^instr[1:0];

  assign op_f   = instr_q[15:13];
  assign mode_f = instr_q[12:11];
  assign rd_f   = instr_q[10:8];
  assign rn_f   = instr_q[7:5];
  assign rm_f   = instr_q[4:2];

  // Opcodes 001, 010 and 101 have no AU function and retire with err.
  always_comb begin
    unique case (op_f)
      3'b000, 3'b011, 3'b100, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  assign accept   = instr_valid && instr_ready;
  assign wb_write = (state_q == S_WB) && op_legal;

  // FSM next-state and handshake/status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        err     = !op_legal;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reset aborts the in-flight instruction. Retirement is not reported,
    // and nothing is accepted while reset is held.
    if (rst) begin
      instr_ready = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then sample the pre-edge values, whatever order the statements are in.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath next-state: latch, operand read, result capture, writeback.
  always_comb begin
    instr_d     = instr_q;
    imm_d       = imm_q;
    au_opcode_d = au_opcode_q;
    au_mode_d   = au_mode_q;
    au_imm_d    = au_imm_q;
    au_rn_d     = au_rn_q;
    au_rm_d     = au_rm_q;
    result_d    = result_q;
    regs_d      = regs_q;

    if (accept) begin
      instr_d = instr[15:2];
      imm_d   = imm;
    end

    // Operands are captured here, before this instruction's own writeback.
    // That makes Rd aliasing Rn/Rm harmless. The previous instruction has
    // already written back by this point, so no forwarding is needed.
    if (state_q == S_READ) begin
      au_opcode_d = op_f;
      au_mode_d   = mode_f;
      au_imm_d    = {1'b0, imm_q};
      au_rn_d     = regs_q[rn_f];
      au_rm_d     = regs_q[rm_f];
    end

    if (state_q == S_EXEC) result_d = au_rd_data;

    if (wb_write) regs_d[rd_f] = result_q;
  end

  // Datapath registers, including the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      imm_q       <= '0;
      au_opcode_q <= '0;
      au_mode_q   <= '0;
      au_imm_q    <= '0;
      au_rn_q     <= '0;
      au_rm_q     <= '0;
      result_q    <= '0;
      // NOTE: the register file is deliberately reset. Software relies on
      // every register reading zero after reset, so it cannot map to a
      // reset-less RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      instr_q     <= instr_d;
      imm_q       <= imm_d;
      au_opcode_q <= au_opcode_d;
      au_mode_q   <= au_mode_d;
      au_imm_q    <= au_imm_d;
      au_rn_q     <= au_rn_d;
      au_rm_q     <= au_rm_d;
      result_q    <= result_d;
      regs_q      <= regs_d;
    end
  end

  assign au_opcode  = au_opcode_q;
  assign au_mode    = au_mode_q;
  assign au_imm     = au_imm_q;
  assign au_rn_data = au_rn_q;
  assign au_rm_data = au_rm_q;

  // Debug port sees the register file directly, so a WB write shows up on
  // the cycle after the WB edge.
  assign dbg_data = regs_q[dbg_addr];

`ifdef AU_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;

  // Flags follow the value written on each legal writeback. An illegal
  // writeback leaves them unchanged.
  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (wb_write) begin
      flag_z_d = (result_q == '0);
      flag_n_d = result_q[DW-1];
    end
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  // Flag tracking is compiled out; this build carries no flag state.
`endif

endmodule

// File: tb/tb_au_sequencer.sv
// ---------------------------------------------------------------------------
// tb_au_sequencer
//   Drives au_sequencer with directed and random instructions. A small
//   combinational AU stands in for the real datapath.
//   Each issued instruction pushes its expected operands, result and error
//   status to a scoreboard. That entry is popped and compared when done
//   pulses. A reference register file (plus flags when AU_SEQ_FLAGS_EN is
//   defined) predicts dbg_data after every retirement.
// ---------------------------------------------------------------------------
module tb_au_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] imm;
  logic [2:0]  au_opcode;
  logic [1:0]  au_mode;
  logic [16:0] au_imm;
  logic [15:0] au_rn_data;
  logic [15:0] au_rm_data;
  logic [15:0] au_rd_data;
  logic        done;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef AU_SEQ_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  au_sequencer #(.NREGS(8), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .imm        (imm),
    .au_opcode  (au_opcode),
    .au_mode    (au_mode),
    .au_imm     (au_imm),
    .au_rn_data (au_rn_data),
    .au_rm_data (au_rm_data),
    .au_rd_data (au_rd_data),
    .done       (done),
    .err        (err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef AU_SEQ_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in AU function. Illegal opcodes give a marker value that must
  // never reach the register file.
  function automatic logic [15:0] alu(input logic [2:0] op, input logic [1:0] md,
                                      input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] im);
    case (op)
      3'b000: return a;
      3'b011: begin
        case (md)
          2'b00:   return a + b;
          2'b01:   return a - b;
          2'b10:   return a & b;
          default: return a | b;
        endcase
      end
      3'b100:  return im;
      3'b110:  return a + im;
      3'b111:  return a - im;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign au_rd_data = alu(au_opcode, au_mode, au_rn_data, au_rm_data, au_imm[15:0]);

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  md;
    logic [2:0]  rd;
    logic [15:0] im;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] val;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_regs [8];
  logic        model_z, model_n;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    model_z = 1'b0;
    model_n = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle. Returns at the negedge of the
  // cycle after retirement, where the next instruction may be driven.
  task automatic issue(input logic [2:0] op, input logic [1:0] md, input logic [2:0] rd,
                       input logic [2:0] rn, input logic [2:0] rm, input logic [15:0] im);
    exp_t e;
    int   n;
    e.op  = op;  e.md = md;  e.rd = rd;  e.im = im;
    e.a   = model_regs[rn];
    e.b   = model_regs[rm];
    e.ill = (op == 3'b001) || (op == 3'b010) || (op == 3'b101);
    e.val = alu(op, md, e.a, e.b, im);
    sb.push_back(e);

    check("ready_idle", instr_ready, 1);
    instr       = {op, md, rd, rn, rm, 2'($urandom_range(0, 3))};
    imm         = im;
    instr_valid = 1'b1;
    @(negedge clk);
    // Garbage with valid high while busy; the sequencer must ignore it.
    instr = 16'($urandom);
    imm   = 16'($urandom);
    n = 1;
    while (!done && n < 8) begin
      check("ready_busy", instr_ready, 0);
      @(negedge clk);
      n++;
    end
    check("latency", n, 3);

    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("done", done, 1);
      check("err", err, e.ill);
      check("ready_wb", instr_ready, 0);
      check("au_opcode", au_opcode, e.op);
      check("au_mode", au_mode, e.md);
      check("au_imm", au_imm, {1'b0, e.im});
      check("au_rn_data", au_rn_data, e.a);
      check("au_rm_data", au_rm_data, e.b);
      dbg_addr = e.rd;
      #1;
      check("dbg_before_wb", dbg_data, model_regs[e.rd]);
      if (!e.ill) begin
        model_regs[e.rd] = e.val;
        model_z = (e.val == 16'h0000);
        model_n = e.val[15];
      end
      @(negedge clk);
      instr_valid = 1'b0;
      #1;
      check("done_pulse", done, 0);
      check("err_pulse", err, 0);
      check("ready_back", instr_ready, 1);
      check("dbg_after_wb", dbg_data, model_regs[e.rd]);
`ifdef AU_SEQ_FLAGS_EN
      check("flag_z", flag_z, model_z);
      check("flag_n", flag_n, model_n);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    imm         = 16'h0000;
    dbg_addr    = 3'd0;
    model_clear();

    // Reset for two cycles, then check the reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_au_opcode", au_opcode, 0);
    check("rst_au_mode", au_mode, 0);
    check("rst_au_imm", au_imm, 0);
    check("rst_au_rn", au_rn_data, 0);
    check("rst_au_rm", au_rm_data, 0);
`ifdef AU_SEQ_FLAGS_EN
    check("rst_flag_z", flag_z, 0);
    check("rst_flag_n", flag_n, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_reg", dbg_data, 0);
    end
    @(negedge clk);

    // MOV imm into R3.
    issue(3'b100, 2'b00, 3'd3, 3'd0, 3'd0, 16'h1234);

    // Register add, then register subtract with wrap-around.
    issue(3'b100, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0005);
    issue(3'b100, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0007);
    issue(3'b011, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0000);
    issue(3'b011, 2'b01, 3'd4, 3'd1, 3'd2, 16'h0000);

    // Back-to-back dependency with Rd == Rn.
    issue(3'b100, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0003);
    issue(3'b110, 2'b00, 3'd1, 3'd1, 3'd0, 16'h0002);
    issue(3'b110, 2'b00, 3'd1, 3'd1, 3'd0, 16'h0002);

    // Illegal opcode: retires with err; R5 and the flags stay unchanged.
    issue(3'b100, 2'b00, 3'd5, 3'd0, 3'd0, 16'hAAAA);
    issue(3'b101, 2'b00, 3'd5, 3'd1, 3'd2, 16'h1111);

    // Random mix over all opcodes, modes and registers.
    for (int k = 0; k < 16; k++)
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));

    // Reset while an instruction is in EXEC: no retirement, registers cleared.
    issue(3'b100, 2'b00, 3'd6, 3'd0, 3'd0, 16'h0001);
    instr       = {3'b100, 2'b00, 3'd6, 3'd0, 3'd0, 2'b00};
    imm         = 16'hBEEF;
    instr_valid = 1'b1;
    @(negedge clk);   // READ
    instr_valid = 1'b0;
    @(negedge clk);   // EXEC
    rst = 1'b1;
    @(negedge clk);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    rst = 1'b0;
    model_clear();
    dbg_addr = 3'd6;
    @(negedge clk);
    #1;
    check("midrst_ready", instr_ready, 1);
    check("midrst_r6", dbg_data, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end

    // Zero result, then negative wrap-around result (flags checked when built in).
    issue(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000);
    issue(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0001);
    check("r0_wrap", dbg_data, 16'hFFFF);
    issue(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
- Multi-cycle controller that accepts 16-bit ALU instructions through a valid/ready handshake.
- Owns an 8x16 register file and reads the Rn/Rm operands from it.
- Drives the AU datapath ports (OpcodeB, Mode, Immediate, Rn_data, Rm_data) and writes the AU result back to Rd.
- Sits between the instruction source (fetch or testbench) and the combinational AU instance.

Parameters:
- NREGS, 8, number of registers in the file; must be 8 to match the 3-bit register fields.
- DW, 16, datapath width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction and immediate present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  [15:13] opcode, [12:11] mode, [10:8] Rd, [7:5] Rn, [4:2] Rm, [1:0] ignored.
- imm  in  16  immediate operand, latched with instr.
- au_opcode  out  3  to AU OpcodeB.
- au_mode  out  2  to AU Mode.
- au_imm  out  17  to AU Immediate; {1'b0, latched imm}.
- au_rn_data  out  16  to AU Rn_data.
- au_rm_data  out  16  to AU Rm_data.
- au_rd_data  in  16  from AU Rd_data.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
- dbg_addr  in  3  register file debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset: state=IDLE, all registers=0, latched instr/imm=0, au_* outputs=0, done=0, err=0, instr_ready=1 in the cycle after reset deasserts.
- States are IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and imm, go to READ. Otherwise stay.
- READ:
  - instr_ready=0.
  - Register au_rn_data=reg[Rn] and au_rm_data=reg[Rm].
  - au_opcode, au_mode and au_imm are driven from the latched fields.
  - Go to EXEC.
- EXEC:
  - AU outputs settle.
  - Latch au_rd_data into a result register.
  - Go to WB.
- WB:
  - Legal opcode (000, 011, 100, 110, 111): reg[Rd] <= result, done=1.
  - Illegal opcode (001, 010, 101): no write, done=1, err=1.
  - Go to IDLE.
- Latency: accept in cycle N, retire (done) in N+3, instr_ready high again in N+4. Throughput is 1 instruction per 4 cycles.
- Back-to-back dependency: the WB write completes before the next READ, so a following instruction reads the updated value. No forwarding is needed.
- Rd==Rn or Rd==Rm is legal; operands are captured in READ, before the write.
- Arithmetic is done by the AU and is mod 2^16; au_rd_data is taken as 16 bits. Wrap-around results (e.g. 0-1=0xFFFF) are written unchanged.
- au_* outputs hold their last values while in IDLE.
- instr_valid is ignored outside IDLE. The source must hold instr and imm until the cycle in which it sees ready.
- dbg_data reflects a WB write from the cycle after the WB edge.
- rst in any state: return to IDLE next cycle, clear the register file, drop the in-flight instruction with no writeback, and emit no done pulse.
- All 8 registers are general purpose; there is no hardwired zero.

Optional Feature:
- Macro: AU_SEQ_FLAGS_EN.
- When defined:
  - Adds outputs flag_z (1) and flag_n (1), both reset to 0.
  - On a legal WB: flag_z <= (result==0), flag_n <= result[15].
  - On an illegal WB the flags are unchanged.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then MOV imm: rst for 2 cycles; instr opcode=100 Rd=3 with imm=0x1234 accepted at N -> done and no err at N+3; dbg_addr=3 gives 0x1234 at N+4; instr_ready=1 at N+4.
- Add-sub register mode: R1=5, R2=7 via MOV imm; opcode=011 mode=00 Rd=4 Rn=1 Rm=2 -> R4=0x000C. Then mode=01 with Rn=1 Rm=2 -> R4=0xFFFE (wrap).
- Dependency and aliasing: R1=0x0003; opcode=110 Rd=1 Rn=1 imm=2, immediately followed by the same instruction -> R1=0x0005 then 0x0007. instr_ready is low for 3 cycles after each accept.
- Illegal opcode: R5=0xAAAA; opcode=101 Rd=5 -> done=1 and err=1 in the same cycle; R5 stays 0xAAAA. With AU_SEQ_FLAGS_EN the flags are unchanged.
- Reset mid-operation: R6=0x0001; accept opcode=100 Rd=6 imm=0xBEEF; assert rst in EXEC -> no done pulse, R6=0, state IDLE and instr_ready=1 in the cycle after rst deasserts.
- Flags (AU_SEQ_FLAGS_EN): opcode=111 Rd=0 Rn=0 imm=0 with R0=0 -> flag_z=1, flag_n=0. Then R0 - 1 -> R0=0xFFFF, flag_z=0, flag_n=1.
